// File: rtl/taus88_sched.sv
// taus88_sched: three-component Tausworthe (taus88) generator sharing one step datapath.
// Define TAUS_SCHED_CNT_EN to add the word_cnt accepted-word counter port.
module taus88_sched #(
    parameter logic [31:0] SEED1 = 32'hffffffff,
    parameter logic [31:0] SEED2 = 32'hffffffff,
    parameter logic [31:0] SEED3 = 32'hffffffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        seed_wr,
    input  logic [1:0]  seed_idx,
    input  logic [31:0] seed_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        seed_err
`ifdef TAUS_SCHED_CNT_EN
    ,
    output logic [31:0] word_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, C1A, C1B, C2A, C2B, C3A, C3B, OUT} state_t;
    state_t      state_q, state_d;
    logic [31:0] s1_q, s2_q, s3_q, l_q, r_q, out_q;
    logic [31:0] cur, l_d, r_d, nxt, seed_min;
    logic        err_q, phase_a, seed_ok, seed_bad;
    // next-state sequencing: one A/B phase pair per component, then hold in OUT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = en ? C1A : IDLE;
            C1A:     state_d = C1B;
            C1B:     state_d = C2A;
            C2A:     state_d = C2B;
            C2B:     state_d = C3A;
            C3A:     state_d = C3B;
            C3B:     state_d = OUT;
            OUT:     state_d = out_ready ? (en ? C1A : IDLE) : OUT;
            default: state_d = IDLE;
        endcase
    end
    // shared step datapath: select the component, apply its shift/mask constants
    always_comb begin
        cur      = (state_q == C1A) ? s1_q : (state_q == C2A) ? s2_q : s3_q;
        l_d      = (state_q == C1A) ? (((cur << 13) ^ cur) >> 19) :
                   (state_q == C2A) ? (((cur << 2) ^ cur) >> 25) : (((cur << 3) ^ cur) >> 11);
        r_d      = (state_q == C1A) ? ((cur & 32'hfffffffe) << 12) :
                   (state_q == C2A) ? ((cur & 32'hfffffff8) << 4) : ((cur & 32'hfffffff0) << 17);
        nxt      = l_q ^ r_q;
        phase_a  = (state_q == C1A) || (state_q == C2A) || (state_q == C3A);
        seed_min = (seed_idx == 2'd1) ? 32'd2 : (seed_idx == 2'd2) ? 32'd8 : 32'd16;
        seed_ok  = (state_q == IDLE) && seed_wr && (seed_idx != 2'd0) && (seed_data >= seed_min);
        seed_bad = (state_q == IDLE) && seed_wr && (seed_idx != 2'd0) && (seed_data < seed_min);
    end
    // state, component registers, phase-A latches, output word and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s1_q    <= SEED1;
            s2_q    <= SEED2;
            s3_q    <= SEED3;
            l_q     <= '0;
            r_q     <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (phase_a) begin
                l_q <= l_d;
                r_q <= r_d;
            end
            if (state_q == C1B) s1_q <= nxt;
            else if (seed_ok && seed_idx == 2'd1) s1_q <= seed_data;
            if (state_q == C2B) s2_q <= nxt;
            else if (seed_ok && seed_idx == 2'd2) s2_q <= seed_data;
            if (state_q == C3B) begin
                s3_q  <= nxt;
                out_q <= s1_q ^ s2_q ^ nxt;
            end else if (seed_ok && seed_idx == 2'd3) s3_q <= seed_data;
            if (seed_bad) err_q <= 1'b1;
        end
    end
    assign out_data  = out_q;
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign seed_err  = err_q;
`ifdef TAUS_SCHED_CNT_EN
    logic [31:0] cnt_q;
    // count accepted transfers, wrapping naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else if (out_valid && out_ready) cnt_q <= cnt_q + 32'd1;
    end
    assign word_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_taus88_sched.sv
// tb_taus88_sched: randomized self-checking bench with a cycle-level behavioural model.
module tb_taus88_sched;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, seed_wr = 1'b0, out_ready = 1'b0;
    logic [1:0]  seed_idx = 2'd0;
    logic [31:0] seed_data = 32'd0;
    logic [31:0] out_data;
    logic        out_valid, busy, seed_err;
    int          total = 0, bad = 0;
`ifdef TAUS_SCHED_CNT_EN
    logic [31:0] word_cnt;
    logic [31:0] mcnt = 32'd0;
`endif

    taus88_sched dut (
        .clk(clk), .rst(rst), .en(en), .seed_wr(seed_wr), .seed_idx(seed_idx),
        .seed_data(seed_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .seed_err(seed_err)
`ifdef TAUS_SCHED_CNT_EN
        , .word_cnt(word_cnt)
`endif
    );

    always #5 clk = ~clk;

    // model: ph counts cycles into a round (0 idle, 1..6 stepping, 7 word ready)
    int          ph = 0;
    logic [31:0] m1 = 32'hffffffff, m2 = 32'hffffffff, m3 = 32'hffffffff, mout = 32'd0;
    logic        merr = 1'b0;

    function automatic logic [31:0] tstep(input logic [31:0] x, input int q, input int s,
                                          input int k, input logic [31:0] m);
        return (((x << q) ^ x) >> s) ^ ((x & m) << k);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = 0; m1 = 32'hffffffff; m2 = 32'hffffffff; m3 = 32'hffffffff;
            mout = 32'd0; merr = 1'b0;
`ifdef TAUS_SCHED_CNT_EN
            mcnt = 32'd0;
`endif
        end else if (ph == 0) begin
            if (seed_wr && seed_idx != 0) begin
                if (seed_data < (seed_idx == 1 ? 32'd2 : seed_idx == 2 ? 32'd8 : 32'd16)) merr = 1'b1;
                else if (seed_idx == 1) m1 = seed_data;
                else if (seed_idx == 2) m2 = seed_data;
                else m3 = seed_data;
            end
            if (en) ph = 1;
        end else if (ph < 6) ph = ph + 1;
        else if (ph == 6) begin
            m1 = tstep(m1, 13, 19, 12, 32'hfffffffe);
            m2 = tstep(m2, 2, 25, 4, 32'hfffffff8);
            m3 = tstep(m3, 3, 11, 17, 32'hfffffff0);
            mout = m1 ^ m2 ^ m3;
            ph = 7;
        end else if (out_ready) begin
`ifdef TAUS_SCHED_CNT_EN
            mcnt = mcnt + 32'd1;
`endif
            ph = en ? 1 : 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, ph != 0});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ph == 7});
        chk("seed_err", {31'd0, seed_err}, {31'd0, merr});
        if (ph == 7 || !rst) chk("out_data", out_data, mout);
        if (ph == 0) begin
            chk("s1", dut.s1_q, m1);
            chk("s2", dut.s2_q, m2);
            chk("s3", dut.s3_q, m3);
        end
`ifdef TAUS_SCHED_CNT_EN
        chk("word_cnt", word_cnt, mcnt);
`endif
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("valid timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
    endtask

    int n;
    initial begin
        repeat (2) @(negedge clk);
        chk("rst out_data", out_data, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        // first word from default seeds
        #2 rst = 1'b1;
        en = 1'b1; out_ready = 1'b1;
        wait_valid(n);
        chk("latency", n, 32'd7);
        chk("word0", out_data, 32'hffe01f80);
        chk("model word0", mout, 32'hffe01f80);
        chk("s1 round", dut.s1_q, 32'hffffe000);
        chk("s2 round", dut.s2_q, 32'hffffff80);
        chk("s3 round", dut.s3_q, 32'hffe00000);
        @(negedge clk); en = 1'b0;
        wait_idle();
        // backpressure hold
        @(negedge clk); en = 1'b1; out_ready = 1'b0;
        wait_valid(n);
        repeat (20) begin
            @(negedge clk);
            chk("hold valid", {31'd0, out_valid}, 32'd1);
            chk("hold data", out_data, mout);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("restart busy", {31'd0, busy}, 32'd1);
        chk("restart valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk); en = 1'b0;
        wait_idle();
        // seed range checks
        @(negedge clk); seed_wr = 1'b1; seed_idx = 2'd2; seed_data = 32'h5;
        @(negedge clk); seed_wr = 1'b0;
        chk("err set", {31'd0, seed_err}, 32'd1);
        seed_wr = 1'b1; seed_data = 32'h8;
        @(negedge clk); seed_wr = 1'b0;
        chk("s2 seeded", dut.s2_q, 32'h8);
        chk("err sticky", {31'd0, seed_err}, 32'd1);
        // seed write mid-round ignored, reset mid-round drops word
        reset_pulse();
        @(negedge clk); en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); seed_wr = 1'b1; seed_idx = 2'd1; seed_data = 32'd0; en = 1'b0;
        @(negedge clk); seed_wr = 1'b0;
        chk("midround err", {31'd0, seed_err}, 32'd0);
        @(negedge clk); #2 rst = 1'b0; #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst valid", {31'd0, out_valid}, 32'd0);
        chk("rst s1", dut.s1_q, 32'hffffffff);
        chk("rst s2", dut.s2_q, 32'hffffffff);
        chk("rst s3", dut.s3_q, 32'hffffffff);
        @(negedge clk); #2 rst = 1'b1;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en        = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            seed_wr   = ($urandom % 6) == 0;
            seed_idx  = 2'($urandom % 4);
            seed_data = ($urandom % 2) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom % 400 == 0) begin
                #2 rst = 1'b0;
                @(negedge clk); #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
